// File: rtl/cordic_out_buffer.sv
// Output buffer for the unrolled CORDIC cosine pipeline: valid shadow, credit-gated issue, FWFT FIFO.
// Optional refused-issue reporting (err_o, drop_cnt) is enabled with CORDIC_OUT_BUFFER_ERR_EN.
module cordic_out_buffer #(
  parameter int LATENCY    = 17,
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   res_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count
`ifdef CORDIC_OUT_BUFFER_ERR_EN
  ,
  output logic                    err_o,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [LATENCY-1:0]    shadow;
  logic [CW-1:0]         inflight;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW:0]           committed;
  logic                  issue;
  logic                  capture;
  logic                  push;
  logic                  pop;

  // Credits cover both queued results and samples still inside the CORDIC pipeline.
  assign committed = {1'b0, count} + {1'b0, inflight};
  assign in_ready  = committed < DEPTH_C;
  assign issue     = in_valid && in_ready;
  assign capture   = shadow[LATENCY-1];
  assign push      = capture;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Stage: valid shadow of the CORDIC pipeline slots
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      inflight <= '0;
    end else begin
      shadow <= {shadow[LATENCY-2:0], issue};
      case ({issue, capture})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  // Stage: capture into FIFO storage (data is not reset)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef CORDIC_OUT_BUFFER_ERR_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o    <= 1'b0;
      drop_cnt <= '0;
    end else if (in_valid && !in_ready) begin
      err_o    <= 1'b1;
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cordic_out_buffer.sv
// Directed bench for cordic_out_buffer; covers the error outputs when CORDIC_OUT_BUFFER_ERR_EN is defined.
module tb_cordic_out_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] res_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  count;
`ifdef CORDIC_OUT_BUFFER_ERR_EN
  logic        err_o;
  logic [15:0] drop_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  cordic_out_buffer #(.LATENCY(17), .DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .res_data (res_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
`ifdef CORDIC_OUT_BUFFER_ERR_EN
    ,
    .err_o    (err_o),
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vecs++; if (count !== 6'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    res_data  = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      res_data = (k == 17) ? 32'h3F800000 : 32'hDEADBEEF;
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid cyc%0d: got %b want 0", k, out_valid); end
      step();
    end
    res_data = 32'hDEADBEEF;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %b want 1", out_valid); end
    vecs++; if (out_data !== 32'h3F800000) begin errs++; $display("FAIL single_data: got %h want 3f800000", out_data); end
    vecs++; if (count !== 6'd1) begin errs++; $display("FAIL single_count: got %0d want 1", count); end
    step();
    step();
    vecs++; if (count !== 6'd1) begin errs++; $display("FAIL single_hold_count: got %0d want 1", count); end
    vecs++; if (out_data !== 32'h3F800000) begin errs++; $display("FAIL single_hold_data: got %h want 3f800000", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
    vecs++; if (count !== 6'd0) begin errs++; $display("FAIL single_pop_count: got %0d want 0", count); end
  endtask

  task automatic test_stream();
    int  nout;
    logic exp_valid;
    nout = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 130; t++) begin
      in_valid  = (t < 100);
      res_data  = 32'h10000000 + t;
      exp_valid = (t >= 18) && (t < 118);
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready t%0d: got %b want 1", t, in_ready); end
      vecs++; if (out_valid !== exp_valid) begin errs++; $display("FAIL stream_valid t%0d: got %b want %b", t, out_valid, exp_valid); end
      vecs++; if (count > 6'd2) begin errs++; $display("FAIL stream_count t%0d: got %0d want <=2", t, count); end
      if (out_valid && exp_valid) begin
        vecs++; if (out_data !== 32'h10000000 + nout + 17) begin errs++; $display("FAIL stream_data #%0d: got %h want %h", nout, out_data, 32'h10000000 + nout + 17); end
        nout++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vecs++; if (nout !== 100) begin errs++; $display("FAIL stream_total: got %0d want 100", nout); end
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0;
    for (int t = 0; t < 22; t++) begin
      in_valid = (t < 6);
      res_data = 32'h30000000 + t;
      step();
    end
    in_valid  = 1'b0;
    res_data  = 32'h30000000 + 22;
    out_ready = 1'b1;
    vecs++; if (count !== 6'd5) begin errs++; $display("FAIL simul_pre_count: got %0d want 5", count); end
    vecs++; if (out_data !== 32'h30000011) begin errs++; $display("FAIL simul_pre_head: got %h want 30000011", out_data); end
    step();
    out_ready = 1'b0;
    vecs++; if (count !== 6'd5) begin errs++; $display("FAIL simul_post_count: got %0d want 5", count); end
    vecs++; if (out_data !== 32'h30000012) begin errs++; $display("FAIL simul_post_head: got %h want 30000012", out_data); end
    for (int j = 1; j <= 5; j++) begin
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL simul_drain_valid #%0d: got %b want 1", j, out_valid); end
      vecs++; if (out_data !== 32'h30000011 + j) begin errs++; $display("FAIL simul_drain_data #%0d: got %h want %h", j, out_data, 32'h30000011 + j); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    vecs++; if (count !== 6'd0) begin errs++; $display("FAIL simul_end_count: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int t = 0; t <= 30; t++) begin
      in_valid = (t <= 8);
      rst      = (t == 8);
      res_data = 32'h40000000 + t;
      if (t >= 9) begin
        vecs++; if (count !== 6'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_capture t%0d: got count=%0d valid=%b want 0/0", t, count, out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_in_ready t%0d: got %b want 1", t, in_ready); end
      end
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int issued;
    logic exp_rdy;
    issued    = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 60; t++) begin
      in_valid = 1'b1;
      res_data = 32'h20000000 + t;
      exp_rdy  = (t < 32);
      vecs++; if (in_ready !== exp_rdy) begin errs++; $display("FAIL bp_in_ready t%0d: got %b want %b", t, in_ready, exp_rdy); end
      if (in_ready) issued++;
      step();
    end
    in_valid = 1'b0;
    vecs++; if (issued !== 32) begin errs++; $display("FAIL bp_issued: got %0d want 32", issued); end
    vecs++; if (count !== 6'd32) begin errs++; $display("FAIL bp_full_count: got %0d want 32", count); end
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_full_valid: got %b want 1", out_valid); end
    for (int j = 0; j < 32; j++) begin
      vecs++; if (out_data !== 32'h20000011 + j) begin errs++; $display("FAIL bp_data #%0d: got %h want %h", j, out_data, 32'h20000011 + j); end
      out_ready = 1'b1;
      step();
      if (j == 0) begin
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_reassert: got %b want 1", in_ready); end
        vecs++; if (count !== 6'd31) begin errs++; $display("FAIL bp_first_pop_count: got %0d want 31", count); end
      end
    end
    out_ready = 1'b0;
    vecs++; if (count !== 6'd0) begin errs++; $display("FAIL bp_end_count: got %0d want 0", count); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_end_valid: got %b want 0", out_valid); end
  endtask

`ifdef CORDIC_OUT_BUFFER_ERR_EN
  task automatic test_err();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (err_o !== 1'b0 || drop_cnt !== 16'd0) begin errs++; $display("FAIL err_reset: got err=%b drop=%0d want 0/0", err_o, drop_cnt); end
    out_ready = 1'b0;
    for (int t = 0; t < 32; t++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL err_full: got in_ready=%b want 0", in_ready); end
    vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL err_not_yet: got %b want 0", err_o); end
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    vecs++; if (err_o !== 1'b1) begin errs++; $display("FAIL err_set: got %b want 1", err_o); end
    vecs++; if (drop_cnt !== 16'd3) begin errs++; $display("FAIL err_drop_cnt: got %0d want 3", drop_cnt); end
    for (int t = 0; t < 5; t++) step();
    vecs++; if (err_o !== 1'b1 || drop_cnt !== 16'd3) begin errs++; $display("FAIL err_sticky: got err=%b drop=%0d want 1/3", err_o, drop_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (err_o !== 1'b0 || drop_cnt !== 16'd0) begin errs++; $display("FAIL err_clear: got err=%b drop=%0d want 0/0", err_o, drop_cnt); end
    vecs++; if (count !== 6'd0) begin errs++; $display("FAIL err_clear_count: got %0d want 0", count); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    res_data  = 32'h0;
    test_reset();
    test_single();
    test_stream();
    test_simul_push_pop();
    test_reset_mid();
    test_backpressure();
`ifdef CORDIC_OUT_BUFFER_ERR_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
